// File: rtl/ccff_bitstream_loader_if.sv
// Word stream carrying the configuration bitstream into the ccff loader.
// The master presents s_data/s_valid and the loader answers with s_ready.
`timescale 1ns/1ps

interface ccff_bitstream_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface : ccff_bitstream_loader_if

// File: rtl/ccff_bitstream_loader.sv
// Serialises 32-bit bitstream words MSB first into a CHAIN_LEN-long ccff chain,
// either loading it or re-sending the stream and counting tail mismatches.
`timescale 1ns/1ps

module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 4096
) (
    input  logic                        prog_clk,
    input  logic                        prog_reset_n,
    input  logic                        start,
    input  logic                        mode,
    ccff_bitstream_loader_if.slave      stream,
    output logic                        ccff_head,
    input  logic                        ccff_tail,
    output logic                        ccff_clk_en,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 err_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    localparam logic [15:0] LAST_BIT  = 16'(CHAIN_LEN - 1);
    localparam logic [4:0]  LAST_WORD = 5'd31;

    state_t      state;
    logic [31:0] sreg;
    logic [15:0] bit_cnt;
    logic [4:0]  word_cnt;
    logic        verify;

    // NOTE: every output is a flop written alongside the state, so each
    // transition also sets the value the outputs must show in the next state.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state          <= IDLE;
            sreg           <= '0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
            verify         <= 1'b0;
            stream.s_ready <= 1'b0;
            ccff_head      <= 1'b0;
            ccff_clk_en    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt        <= '0;
                        word_cnt       <= '0;
                        err_count      <= '0;
                        verify         <= mode;
                        stream.s_ready <= 1'b1;
                        busy           <= 1'b1;
                        state          <= FETCH;
                    end
                end

                FETCH: begin
                    if (stream.s_valid) begin
                        sreg           <= stream.s_data;
                        word_cnt       <= '0;
                        stream.s_ready <= 1'b0;
                        ccff_clk_en    <= 1'b1;
                        ccff_head      <= stream.s_data[31];
                        state          <= SHIFT;
                    end
                end

                SHIFT: begin
                    sreg     <= {sreg[30:0], 1'b0};
                    bit_cnt  <= bit_cnt + 16'd1;
                    word_cnt <= word_cnt + 5'd1;

                    // The tail replays the previously loaded stream in step with the head.
                    if (verify && (ccff_tail != ccff_head) && (err_count != 16'hFFFF)) begin
                        err_count <= err_count + 16'd1;
                    end

                    if (bit_cnt == LAST_BIT) begin
                        ccff_clk_en <= 1'b0;
                        ccff_head   <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (word_cnt == LAST_WORD) begin
                        ccff_clk_en    <= 1'b0;
                        ccff_head      <= 1'b0;
                        stream.s_ready <= 1'b1;
                        state          <= FETCH;
                    end else begin
                        // Head leads the shift so it shows the bit about to become sreg[31].
                        ccff_head <= sreg[30];
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : ccff_bitstream_loader

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 40-bit chain with a behavioural chain model
// and a 5-bit chain, checked against a scoreboard of expected head bits.
`timescale 1ns/1ps

module tb_ccff_bitstream_loader;

    localparam int LEN_A = 40;
    localparam int LEN_B = 5;

    logic prog_clk = 1'b0;
    logic prog_reset_n = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        a_start = 1'b0, a_mode = 1'b0;
    logic        a_head, a_tail, a_clk_en, a_busy, a_done;
    logic [15:0] a_err;
    logic        b_start = 1'b0, b_mode = 1'b0;
    logic        b_head, b_clk_en, b_busy, b_done;
    logic        b_tail = 1'b0;
    logic [15:0] b_err;

    ccff_bitstream_loader_if a_if ();
    ccff_bitstream_loader_if b_if ();

    ccff_bitstream_loader #(.CHAIN_LEN(LEN_A)) dut_a (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (a_start),
        .mode         (a_mode),
        .stream       (a_if),
        .ccff_head    (a_head),
        .ccff_tail    (a_tail),
        .ccff_clk_en  (a_clk_en),
        .busy         (a_busy),
        .done         (a_done),
        .err_count    (a_err)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(LEN_B)) dut_b (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (b_start),
        .mode         (b_mode),
        .stream       (b_if),
        .ccff_head    (b_head),
        .ccff_tail    (b_tail),
        .ccff_clk_en  (b_clk_en),
        .busy         (b_busy),
        .done         (b_done),
        .err_count    (b_err)
    );

    // Behavioural chain: captures the head on every enabled edge.
    logic [LEN_A-1:0] chain = '0;
    assign a_tail = chain[LEN_A-1];
    always @(posedge prog_clk) begin
        if (a_clk_en === 1'b1) chain <= {chain[LEN_A-2:0], a_head};
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    logic sb[$];

    // Drives one pass on the 40-bit DUT, feeding two words and checking each head bit.
    task automatic pass_a(input logic m, input logic [31:0] w0, input logic [31:0] w1,
                          input int gap, input bit poke, output int shifts, output int done_cyc);
        logic [31:0] words [2];
        int   widx = 0;
        int   pushed = 0;
        int   gap_left = gap;
        int   cyc = 0;
        bit   finished = 1'b0;
        logic exp_bit;
        words[0] = w0;
        words[1] = w1;
        shifts = 0;
        done_cyc = -1;
        sb.delete();
        @(negedge prog_clk);
        a_start = 1'b1;
        a_mode  = m;
        while (!finished && cyc < 200) begin
            @(negedge prog_clk);
            cyc++;
            a_start = 1'b0;
            a_mode  = m;
            if (poke && cyc == 12) begin
                a_start = 1'b1;
                a_mode  = ~m;
            end
            n_cmp++;
            if (a_busy !== 1'b1) begin
                n_bad++; $display("FAIL busy_in_pass cyc=%0d: got %b want 1", cyc, a_busy);
            end
            if (a_clk_en === 1'b1) begin
                shifts++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL extra_shift cyc=%0d: got shift want none", cyc);
                end else begin
                    exp_bit = sb.pop_front();
                    if (a_head !== exp_bit) begin
                        n_bad++; $display("FAIL head_bit cyc=%0d: got %b want %b", cyc, a_head, exp_bit);
                    end
                end
                n_cmp++;
                if (a_if.s_ready !== 1'b0) begin
                    n_bad++; $display("FAIL ready_in_shift cyc=%0d: got %b want 0", cyc, a_if.s_ready);
                end
            end else begin
                n_cmp++;
                if (a_head !== 1'b0) begin
                    n_bad++; $display("FAIL head_idle cyc=%0d: got %b want 0", cyc, a_head);
                end
            end
            if (a_done === 1'b1) begin
                done_cyc = cyc;
                finished = 1'b1;
            end
            if (a_if.s_ready === 1'b1 && widx < 2) begin
                if (widx == 1 && gap_left > 0) begin
                    n_cmp++;
                    if (a_clk_en !== 1'b0) begin
                        n_bad++; $display("FAIL stall_clk_en cyc=%0d: got %b want 0", cyc, a_clk_en);
                    end
                    gap_left--;
                    a_if.s_valid = 1'b0;
                end else begin
                    a_if.s_valid = 1'b1;
                    a_if.s_data  = words[widx];
                    for (int i = 31; i >= 0 && pushed < LEN_A; i--) begin
                        sb.push_back(words[widx][i]);
                        pushed++;
                    end
                    widx++;
                end
            end else begin
                a_if.s_valid = 1'b0;
            end
        end
        n_cmp++;
        if (!finished) begin
            n_bad++; $display("FAIL done_timeout: got no done want done within 200 cycles");
        end
        n_cmp++;
        if (gap_left != 0) begin
            n_bad++; $display("FAIL stall_length: got %0d stall cycles left want 0", gap_left);
        end
        @(negedge prog_clk);
        n_cmp++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_if.s_ready !== 1'b0) begin
            n_bad++; $display("FAIL after_done: got done=%b busy=%b ready=%b want 0/0/0",
                              a_done, a_busy, a_if.s_ready);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover: got %0d unshifted bits want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        a_if.s_valid = 1'b0; a_if.s_data = '0;
        b_if.s_valid = 1'b0; b_if.s_data = '0;
        repeat (3) @(negedge prog_clk);
        n_cmp++;
        if ({a_if.s_ready, a_head, a_clk_en, a_busy, a_done, a_err} !== 21'd0) begin
            n_bad++; $display("FAIL reset_a: got rdy=%b head=%b en=%b busy=%b done=%b err=%h want all 0",
                              a_if.s_ready, a_head, a_clk_en, a_busy, a_done, a_err);
        end
        n_cmp++;
        if ({b_if.s_ready, b_head, b_clk_en, b_busy, b_done, b_err} !== 21'd0) begin
            n_bad++; $display("FAIL reset_b: got rdy=%b head=%b en=%b busy=%b done=%b err=%h want all 0",
                              b_if.s_ready, b_head, b_clk_en, b_busy, b_done, b_err);
        end
        prog_reset_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        n_cmp++;
        if (a_busy !== 1'b0 || a_if.s_ready !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: got busy=%b ready=%b want 0/0", a_busy, a_if.s_ready);
        end
    endtask

    task automatic check_pass(input string name, input int shifts, input int done_cyc,
                              input int want_done, input logic [15:0] want_err,
                              input logic [LEN_A-1:0] want_chain);
        n_cmp++;
        if (shifts != LEN_A) begin
            n_bad++; $display("FAIL %s_shifts: got %0d want %0d", name, shifts, LEN_A);
        end
        n_cmp++;
        if (done_cyc != want_done) begin
            n_bad++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, want_done);
        end
        n_cmp++;
        if (a_err !== want_err) begin
            n_bad++; $display("FAIL %s_err_count: got %h want %h", name, a_err, want_err);
        end
        n_cmp++;
        if (chain !== want_chain) begin
            n_bad++; $display("FAIL %s_chain: got %h want %h", name, chain, want_chain);
        end
    endtask

    task automatic test_load();
        int sh, dc;
        pass_a(1'b0, 32'hA5A5_0F0F, 32'hC35A_7E11, 0, 1'b1, sh, dc);
        check_pass("load", sh, dc, 43, 16'h0000, {32'hA5A5_0F0F, 8'hC3});
    endtask

    task automatic test_verify_match();
        int sh, dc;
        pass_a(1'b1, 32'hA5A5_0F0F, 32'hC3FF_0000, 0, 1'b0, sh, dc);
        check_pass("verify_match", sh, dc, 43, 16'h0000, {32'hA5A5_0F0F, 8'hC3});
    endtask

    task automatic test_verify_mismatch();
        int sh, dc;
        pass_a(1'b1, 32'hA5A5_0F0E, 32'hC35A_7E11, 0, 1'b0, sh, dc);
        check_pass("verify_mismatch", sh, dc, 43, 16'h0001, {32'hA5A5_0F0E, 8'hC3});
        repeat (4) @(negedge prog_clk);
        n_cmp++;
        if (a_err !== 16'h0001) begin
            n_bad++; $display("FAIL err_hold: got %h want 0001", a_err);
        end
    endtask

    task automatic test_stall_gap();
        int sh, dc;
        pass_a(1'b0, 32'h3C96_E187, 32'h9BDF_0123, 5, 1'b0, sh, dc);
        check_pass("stall_load", sh, dc, 48, 16'h0000, {32'h3C96_E187, 8'h9B});
        pass_a(1'b1, 32'h3C96_E187, 32'h9B00_FFFF, 5, 1'b1, sh, dc);
        check_pass("stall_verify", sh, dc, 48, 16'h0000, {32'h3C96_E187, 8'h9B});
    endtask

    task automatic test_reset_mid_pass();
        int shifts = 0;
        int cyc = 0;
        logic [LEN_A-1:0] snap;
        @(negedge prog_clk);
        a_start = 1'b1; a_mode = 1'b0;
        a_if.s_valid = 1'b1; a_if.s_data = 32'hFFFF_FFFF;
        while (shifts < 17 && cyc < 100) begin
            @(negedge prog_clk);
            cyc++;
            a_start = 1'b0;
            if (a_clk_en === 1'b1) shifts++;
        end
        n_cmp++;
        if (shifts != 17) begin
            n_bad++; $display("FAIL midreset_reach: got %0d shifts want 17", shifts);
        end
        prog_reset_n = 1'b0;
        a_if.s_valid = 1'b0;
        @(negedge prog_clk);
        snap = chain;
        n_cmp++;
        if ({a_if.s_ready, a_head, a_clk_en, a_busy, a_done, a_err} !== 21'd0) begin
            n_bad++; $display("FAIL midreset_outputs: got rdy=%b head=%b en=%b busy=%b done=%b err=%h want all 0",
                              a_if.s_ready, a_head, a_clk_en, a_busy, a_done, a_err);
        end
        prog_reset_n = 1'b1;
        repeat (5) begin
            @(negedge prog_clk);
            n_cmp++;
            if (a_clk_en !== 1'b0 || a_busy !== 1'b0) begin
                n_bad++; $display("FAIL midreset_idle: got en=%b busy=%b want 0/0", a_clk_en, a_busy);
            end
        end
        n_cmp++;
        if (chain !== snap) begin
            n_bad++; $display("FAIL midreset_chain: got %h want %h", chain, snap);
        end
    endtask

    task automatic short_pass(input logic [31:0] word);
        int   shifts = 0;
        int   cyc = 0;
        int   done_cyc = -1;
        logic exp_bit;
        sb.delete();
        for (int i = 31; i > 31 - LEN_B; i--) sb.push_back(word[i]);
        @(negedge prog_clk);
        b_start = 1'b1; b_mode = 1'b0;
        b_if.s_valid = 1'b1; b_if.s_data = word;
        while (done_cyc < 0 && cyc < 30) begin
            @(negedge prog_clk);
            cyc++;
            b_start = 1'b0;
            if (b_clk_en === 1'b1) begin
                shifts++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL short_extra_shift cyc=%0d: got shift want none", cyc);
                end else begin
                    exp_bit = sb.pop_front();
                    if (b_head !== exp_bit) begin
                        n_bad++; $display("FAIL short_head cyc=%0d: got %b want %b", cyc, b_head, exp_bit);
                    end
                end
            end
            if (b_done === 1'b1) done_cyc = cyc;
        end
        b_if.s_valid = 1'b0;
        n_cmp++;
        if (shifts != LEN_B) begin
            n_bad++; $display("FAIL short_shifts: got %0d want %0d", shifts, LEN_B);
        end
        n_cmp++;
        if (done_cyc != 7) begin
            n_bad++; $display("FAIL short_done_cycle: got %0d want 7", done_cyc);
        end
        @(negedge prog_clk);
        n_cmp++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || b_err !== 16'h0000) begin
            n_bad++; $display("FAIL short_after: got busy=%b done=%b err=%h want 0/0/0000", b_busy, b_done, b_err);
        end
    endtask

    task automatic test_short_chain();
        short_pass(32'hF800_0000);
        short_pass(32'h5000_0000);
    endtask

    initial begin
        test_reset();
        test_load();
        test_verify_match();
        test_verify_mismatch();
        test_stall_gap();
        test_reset_mid_pass();
        test_short_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ccff_bitstream_loader
